// File: rtl/led_show_pkg.sv
// Shared types and helpers for the LED light-show sequencer.
// Optional build macro: LED_SHOW_PINGPONG_EN (see led_show_seq.sv).
package led_show_pkg;

  localparam int MAX_ZONES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CENTRE_FILL = 2'd0,
    SWEEP       = 2'd1,
    EDGE_RUN    = 2'd2
  } mode_e;

  // Number of frames in one pass of the given pattern for an n-LED strip.
  function automatic int frame_len(mode_e m, int n);
    return (m == CENTRE_FILL) ? (n / 2 + 1) : n;
  endfunction

  // Expands the per-zone enables into the enable for LED bit i.
  function automatic logic zone_mask_bit(logic [MAX_ZONES-1:0] en, int i,
                                         int n_leds, int n_zones);
    int zone_size;
    zone_size = n_leds / n_zones;
    return en[i / zone_size];
  endfunction

endpackage

// File: rtl/led_show_seq_if.sv
// Control/status bundle between the show controller and the sequencer.
interface led_show_seq_if #(
  parameter int N_LEDS   = 10,
  parameter int N_ZONES  = 2,
  parameter int REPEAT_W = 4
);
  localparam int FW = $clog2(N_LEDS);

  logic                tick;
  logic                start;
  logic                stop;
  logic [1:0]          mode;
  logic [REPEAT_W-1:0] repeats;
  logic [N_ZONES-1:0]  zone_en;
  logic [N_LEDS-1:0]   led_out;
  logic [FW-1:0]       frame_idx;
  logic [REPEAT_W-1:0] reps_left;
  logic                busy;
  logic                done;

  modport master (
    output tick, start, stop, mode, repeats, zone_en,
    input  led_out, frame_idx, reps_left, busy, done
  );

  modport slave (
    input  tick, start, stop, mode, repeats, zone_en,
    output led_out, frame_idx, reps_left, busy, done
  );
endinterface

// File: rtl/led_show_rom.sv
// Combinational frame lookup: (mode, frame) -> LED pattern.
module led_show_rom
  import led_show_pkg::*;
#(
  parameter int N_LEDS = 10
) (
  input  mode_e                       mode,
  input  logic [$clog2(N_LEDS)-1:0]   frame,
  output logic [N_LEDS-1:0]           pattern
);
  localparam int H = N_LEDS / 2;

  int f_int;

  // Build each bit from the pattern's closed-form rule for this frame.
  always_comb begin
    pattern = '0;
    f_int   = int'(frame);
    for (int i = 0; i < N_LEDS; i++) begin
      case (mode)
        CENTRE_FILL: pattern[i] = (i >= H - f_int) && (i <= H + f_int - 1);
        SWEEP:       pattern[i] = (i == f_int);
        EDGE_RUN:    pattern[i] = (i == 0) || (i == N_LEDS - 1) || (i == f_int);
        default:     pattern[i] = 1'b0;
      endcase
    end
  end
endmodule

// File: rtl/led_show_seq.sv
// LED light-show sequencer: plays procedural patterns per tick, with
// programmable pass count and zone gating.
// Define LED_SHOW_PINGPONG_EN to play every even-numbered pass in reverse.
module led_show_seq
  import led_show_pkg::*;
#(
  parameter int N_LEDS   = 10,
  parameter int N_ZONES  = 2,
  parameter int REPEAT_W = 4
) (
  input  logic           clk,
  input  logic           resetBtn,
  led_show_seq_if.slave  bus
);
  localparam int FW = $clog2(N_LEDS);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [N_LEDS-1:0]   pattern_q, pattern_d;
  logic [FW-1:0]       frame_idx_q, frame_idx_d;
  logic [REPEAT_W-1:0] reps_left_q, reps_left_d;
  logic                rev_q, rev_d;
  logic                done_q, done_d;

  logic [N_LEDS-1:0]   rom_pattern;
  logic [N_LEDS-1:0]   zone_mask;
  logic [FW-1:0]       last_idx;
  logic                pass_end;
  logic                next_rev;

  led_show_rom #(.N_LEDS(N_LEDS)) u_rom (
    .mode    (mode_q),
    .frame   (frame_idx_q),
    .pattern (rom_pattern)
  );

  assign last_idx = FW'(frame_len(mode_q, N_LEDS) - 1);

  // Register all sequencer state; reset clears the show immediately.
  always_ff @(posedge clk or negedge resetBtn) begin
    if (!resetBtn) begin
      state_q     <= IDLE;
      mode_q      <= CENTRE_FILL;
      pattern_q   <= '0;
      frame_idx_q <= '0;
      reps_left_q <= '0;
      rev_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pattern_q   <= pattern_d;
      frame_idx_q <= frame_idx_d;
      reps_left_q <= reps_left_d;
      rev_q       <= rev_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: start/stop handling, frame stepping and pass accounting.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pattern_d   = pattern_q;
    frame_idx_d = frame_idx_q;
    reps_left_d = reps_left_q;
    rev_d       = rev_q;
    done_d      = 1'b0;
    pass_end    = 1'b0;
    next_rev    = 1'b0;

    case (state_q)
      IDLE: begin
        pattern_d = '0;
        if (bus.start && !bus.stop) begin
          state_d     = RUN;
          mode_d      = (bus.mode == 2'd3) ? CENTRE_FILL : mode_e'(bus.mode);
          reps_left_d = bus.repeats;
          frame_idx_d = '0;
          rev_d       = 1'b0;
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_d     = IDLE;
          pattern_d   = '0;
          frame_idx_d = '0;
          reps_left_d = '0;
          rev_d       = 1'b0;
        end else if (bus.tick) begin
          pattern_d = rom_pattern;
          if (rev_q) begin
            if (frame_idx_q == '0) pass_end = 1'b1;
            else frame_idx_d = frame_idx_q - 1'b1;
          end else begin
            if (frame_idx_q == last_idx) pass_end = 1'b1;
            else frame_idx_d = frame_idx_q + 1'b1;
          end
          if (pass_end) begin
`ifdef LED_SHOW_PINGPONG_EN
            next_rev = ~rev_q;
`else
            next_rev = 1'b0;
`endif
            rev_d       = next_rev;
            frame_idx_d = next_rev ? last_idx : '0;
            if (reps_left_q != '0) begin
              reps_left_d = reps_left_q - 1'b1;
              if (reps_left_q == REPEAT_W'(1)) state_d = DONE;
            end
          end
        end
      end

      DONE: begin
        pattern_d = '0;
        done_d    = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Zone gating is combinational so switch changes show up immediately.
  always_comb begin
    zone_mask = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      zone_mask[i] = zone_mask_bit(MAX_ZONES'(bus.zone_en), i, N_LEDS, N_ZONES);
    end
  end

  assign bus.led_out   = pattern_q & zone_mask;
  assign bus.frame_idx = frame_idx_q;
  assign bus.reps_left = reps_left_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
endmodule
